// File: rtl/irrigation_pkg.sv
// rtl/irrigation_pkg.sv - shared state, mode and tick-count definitions for the irrigation sequencer
package irrigation_pkg;

  // Width of every slow-tick counter in the sequencer
  localparam int TICK_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WATER = 2'd1,
    ST_DONE  = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [1:0] MODE_OFF       = 2'b00;
  localparam logic [1:0] MODE_SPRINKLER = 2'b01;
  localparam logic [1:0] MODE_DRIP      = 2'b10;
  localparam logic [1:0] MODE_RESERVED  = 2'b11;

  // Only sprinkler and drip open a valve; off and reserved never start a cycle
  function automatic logic mode_is_watering(input logic [1:0] m);
    return (m == MODE_SPRINKLER) || (m == MODE_DRIP);
  endfunction

endpackage

// File: rtl/tick_sync.sv
// rtl/tick_sync.sv - synchronizes slow_clk into clk and emits a one-cycle tick per rising edge
module tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic slow_clk,
  output logic tick
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic [1:0] primed;
  logic       armed;

  // Two-flop synchronizer, edge history, and an arm flag. The reset value of
  // sync2 is not a real sample, so ticks stay suppressed until the
  // synchronizer has delivered a genuine low level of slow_clk; a slow_clk
  // held high across reset release therefore never produces a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      prev   <= 1'b0;
      primed <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sync1  <= slow_clk;
      sync2  <= sync1;
      prev   <= sync2;
      primed <= {primed[0], 1'b1};
      if (primed[1] && !sync2) begin
        armed <= 1'b1;
      end
    end
  end

  assign tick = armed & sync2 & ~prev;

endmodule

// File: rtl/irrigation_sequencer.sv
// rtl/irrigation_sequencer.sv - watering cycle FSM with slow-tick countdown, valve drive and tank-low alarm
module irrigation_sequencer
  import irrigation_pkg::*;
#(
  parameter int SPRINKLER_TICKS = 20,
  parameter int DRIP_TICKS      = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slow_clk,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              tank_low,
  input  logic              stop,
  output logic              valve_sprinkler,
  output logic              valve_drip,
  output logic              busy,
  output logic              done,
  output logic              alarm,
  output logic [TICK_W-1:0] remaining
);

  localparam logic [TICK_W-1:0] SPRINKLER_LOAD = TICK_W'(SPRINKLER_TICKS);
  localparam logic [TICK_W-1:0] DRIP_LOAD      = TICK_W'(DRIP_TICKS);
  localparam logic [TICK_W-1:0] ONE            = TICK_W'(1);

  state_t            state;
  state_t            state_n;
  logic [1:0]        mode_q;
  logic [1:0]        mode_n;
  logic [TICK_W-1:0] rem_q;
  logic [TICK_W-1:0] rem_n;
  logic              tick;

  tick_sync u_tick_sync (
    .clk      (clk),
    .rst      (rst),
    .slow_clk (slow_clk),
    .tick     (tick)
  );

  // State, latched mode and countdown registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_q <= MODE_OFF;
      rem_q  <= '0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
      rem_q  <= rem_n;
    end
  end

  // Next-state/countdown logic; outputs decode only registered state so a
  // reset closes the valves without waiting for a clock
  always_comb begin
    state_n         = state;
    mode_n          = mode_q;
    rem_n           = rem_q;
    valve_sprinkler = 1'b0;
    valve_drip      = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    alarm           = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && tank_low) begin
          state_n = ST_ALARM;
        end else if (start && mode_is_watering(mode)) begin
          mode_n  = mode;
          rem_n   = (mode == MODE_SPRINKLER) ? SPRINKLER_LOAD : DRIP_LOAD;
          state_n = ST_WATER;
        end
      end

      ST_WATER: begin
        busy            = 1'b1;
        valve_sprinkler = (mode_q == MODE_SPRINKLER);
        valve_drip      = (mode_q == MODE_DRIP);
        // stop outranks tank_low, which outranks the countdown
        if (stop) begin
          rem_n   = '0;
          state_n = ST_IDLE;
        end else if (tank_low) begin
          rem_n   = '0;
          state_n = ST_ALARM;
        end else if (tick) begin
          if (rem_q > ONE) begin
            rem_n = rem_q - ONE;
          end else begin
            rem_n   = '0;
            state_n = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end

      ST_ALARM: begin
        alarm = 1'b1;
        if (stop && !tank_low) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign remaining = rem_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// tb/tb_irrigation_sequencer.sv - self-checking bench for irrigation_sequencer
module tb_irrigation_sequencer;

  localparam int S_T = 3;
  localparam int D_T = 5;

  localparam int P_IDLE  = 0;
  localparam int P_WATER = 1;
  localparam int P_DONE  = 2;
  localparam int P_ALARM = 3;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       slow_clk = 1'b0;
  logic       start    = 1'b0;
  logic [1:0] mode     = 2'b00;
  logic       tank_low = 1'b0;
  logic       stop     = 1'b0;
  logic       valve_sprinkler;
  logic       valve_drip;
  logic       busy;
  logic       done;
  logic       alarm;
  logic [5:0] remaining;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  int m_phase = P_IDLE;
  int m_rem   = 0;
  int m_mode  = 0;
  bit hist[$];

  irrigation_sequencer #(
    .SPRINKLER_TICKS (S_T),
    .DRIP_TICKS      (D_T)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .slow_clk        (slow_clk),
    .start           (start),
    .mode            (mode),
    .tank_low        (tank_low),
    .stop            (stop),
    .valve_sprinkler (valve_sprinkler),
    .valve_drip      (valve_drip),
    .busy            (busy),
    .done            (done),
    .alarm           (alarm),
    .remaining       (remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // A slow_clk rise counts once it has crossed two flops: a tick acts on
  // this edge when the sample two edges back is 1 and the one before it is 0,
  // looking only at samples taken since reset release.
  function automatic bit model_tick();
    int n;
    n = hist.size();
    return (n >= 3) && hist[n-2] && !hist[n-3];
  endfunction

  // Behavioural model of the watering cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= P_IDLE;
      m_rem   <= 0;
      m_mode  <= 0;
      hist.delete();
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (start && tank_low) m_phase <= P_ALARM;
          else if (start && (mode == 2'b01 || mode == 2'b10)) begin
            m_mode  <= int'(mode);
            m_rem   <= (mode == 2'b01) ? S_T : D_T;
            m_phase <= P_WATER;
          end
        end
        P_WATER: begin
          if (stop) begin
            m_phase <= P_IDLE;
            m_rem   <= 0;
          end else if (tank_low) begin
            m_phase <= P_ALARM;
            m_rem   <= 0;
          end else if (model_tick()) begin
            if (m_rem <= 1) begin
              m_rem   <= 0;
              m_phase <= P_DONE;
            end else begin
              m_rem <= m_rem - 1;
            end
          end
        end
        P_DONE:  m_phase <= P_IDLE;
        default: if (stop && !tank_low) m_phase <= P_IDLE;
      endcase
      hist.push_back(slow_clk);
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    check("busy", busy, m_phase == P_WATER);
    check("valve_sprinkler", valve_sprinkler, (m_phase == P_WATER) && (m_mode == 1));
    check("valve_drip", valve_drip, (m_phase == P_WATER) && (m_mode == 2));
    check("done", done, m_phase == P_DONE);
    check("alarm", alarm, m_phase == P_ALARM);
    check("remaining", int'(remaining), m_rem);
    check("valve_exclusive", valve_sprinkler & valve_drip, 0);
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic slow_rise();
    slow_clk = 1'b1;
    cyc(3);
    slow_clk = 1'b0;
    cyc(3);
  endtask

  task automatic start_cycle(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    check(name, int'(valve_sprinkler) + int'(valve_drip) + int'(busy)
                + int'(done) + int'(alarm) + int'(remaining), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: simulation did not finish, expected finish", $time);
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #22 rst = 1'b0;
    cyc(6);
    check_quiet("reset_outputs");
    check("model_reset_rem", m_rem, 0);

    // Sprinkler runs full length: 3 -> 2 -> 1 -> done -> idle
    start_cycle(2'b01);
    check("spr_rem_load", int'(remaining), 3);
    check("model_spr_rem_load", m_rem, 3);
    check("spr_valve", valve_sprinkler, 1);
    check("spr_busy", busy, 1);
    slow_rise();
    check("spr_rem_2", int'(remaining), 2);
    slow_rise();
    check("spr_rem_1", int'(remaining), 1);
    slow_rise();
    check("spr_done_count", done_cnt, 1);
    check_quiet("spr_idle_after");

    // Drip stopped after two ticks
    start_cycle(2'b10);
    check("drip_rem_load", int'(remaining), 5);
    check("drip_valve", valve_drip, 1);
    slow_rise();
    slow_rise();
    check("drip_rem_before_stop", int'(remaining), 3);
    check("model_drip_rem", m_rem, 3);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check_quiet("drip_after_stop");
    check("drip_no_done", done_cnt, 1);

    // Mode/start changes ignored mid-water, tank low at remaining 2
    start_cycle(2'b01);
    mode  = 2'b10;
    start = 1'b1;
    slow_rise();
    start = 1'b0;
    check("alm_rem_2", int'(remaining), 2);
    check("alm_valve_kept", valve_sprinkler, 1);
    check("alm_drip_closed", valve_drip, 0);
    tank_low = 1'b1;
    cyc(1);
    check("alm_alarm", alarm, 1);
    check("alm_valves", int'(valve_sprinkler) + int'(valve_drip), 0);
    check("alm_rem_0", int'(remaining), 0);
    stop = 1'b1;
    cyc(1);
    check("alm_hold", alarm, 1);
    tank_low = 1'b0;
    cyc(1);
    stop = 1'b0;
    check_quiet("alm_cleared");

    // Reserved and off modes are ignored
    mode  = 2'b11;
    start = 1'b1;
    cyc(3);
    check_quiet("mode_reserved");
    mode = 2'b00;
    cyc(3);
    check_quiet("mode_off");
    tank_low = 1'b1;
    cyc(1);
    start = 1'b0;
    check("idle_tank_alarm", alarm, 1);
    tank_low = 1'b0;
    stop     = 1'b1;
    cyc(1);
    stop = 1'b0;
    check_quiet("idle_alarm_cleared");

    // stop and tank_low together: stop wins
    start_cycle(2'b10);
    stop     = 1'b1;
    tank_low = 1'b1;
    cyc(1);
    check("both_alarm", alarm, 0);
    check("both_busy", busy, 0);
    stop = 1'b0;
    cyc(2);
    check("both_alarm_later", alarm, 0);
    tank_low = 1'b0;

    // Asynchronous reset mid-water, slow_clk held high through release
    start_cycle(2'b01);
    slow_rise();
    check("rst_rem_before", int'(remaining), 2);
    #3 slow_clk = 1'b1;
    rst = 1'b1;
    #1 check_quiet("rst_immediate");
    cyc(2);
    #2 rst = 1'b0;
    cyc(8);
    check_quiet("rst_released_high");
    check("rst_no_done", done_cnt, 1);
    start_cycle(2'b01);
    cyc(6);
    check("rst_no_tick", int'(remaining), 3);
    slow_clk = 1'b0;
    cyc(3);
    slow_rise();
    check("rst_first_tick", int'(remaining), 2);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(2);
    check_quiet("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irrigation_sequencer.md
IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter SPRINKLER_TICKS, default 20, SHALL set the sprinkler watering duration in slow ticks (legal range 1..63).
REQ-003 Parameter DRIP_TICKS, default 40, SHALL set the drip watering duration in slow ticks (legal range 1..63).
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 slow_clk  in  1  divided clock from the upstream divider, treated as asynchronous.
REQ-007 start  in  1  level request to begin a watering cycle.
REQ-008 mode  in  2  watering mode: 00 off, 01 sprinkler, 10 drip, 11 reserved.
REQ-009 tank_low  in  1  water-tank-low sensor, 1 = insufficient water.
REQ-010 stop  in  1  abort request; also clears the alarm.
REQ-011 valve_sprinkler  out  1  sprinkler valve drive.
REQ-012 valve_drip  out  1  drip valve drive.
REQ-013 busy  out  1  high while in WATER.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 alarm  out  1  tank-low alarm.
REQ-016 remaining  out  6  slow ticks left in the current cycle.

Function
REQ-017 slow_clk SHALL pass through a 2-flop synchronizer; tick SHALL be high for exactly one clk cycle when synchronized slow_clk is 1 and its previous registered value is 0.
REQ-018 The FSM SHALL have states IDLE, WATER, DONE and ALARM, with all outputs decoded from registered state.
REQ-019 IDLE: if start=1 and tank_low=1, go to ALARM; else if start=1 and mode is 01 or 10, latch mode, load remaining with SPRINKLER_TICKS or DRIP_TICKS respectively, and go to WATER.
REQ-020 IDLE: start with mode 00 or 11 SHALL be ignored.
REQ-021 WATER: valve_sprinkler SHALL equal (latched mode==01) and valve_drip SHALL equal (latched mode==10); busy SHALL be 1.
REQ-022 WATER transition priority SHALL be stop, then tank_low, then tick.
REQ-023 WATER, stop=1: go to IDLE and clear remaining to 0.
REQ-024 WATER, tank_low=1: go to ALARM and clear remaining to 0.
REQ-025 WATER, tick=1 and remaining>1: decrement remaining.
REQ-026 WATER, tick=1 and remaining==1: set remaining to 0 and go to DONE.
REQ-027 WATER: start and changes on mode SHALL be ignored.
REQ-028 DONE: done=1 for exactly one cycle, valves 0, then go to IDLE unconditionally.
REQ-029 ALARM: alarm=1 and valves 0; go to IDLE only when stop=1 and tank_low=0 in the same cycle.
REQ-030 remaining SHALL never wrap below 0.
REQ-031 The sprinkler and drip valves SHALL never be high simultaneously.

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE, latched mode 00, remaining 0 and all synchronizer flops 0.
REQ-033 rst=1 SHALL force all outputs to 0.
REQ-034 Reset mid-WATER SHALL close both valves immediately with no done pulse.
REQ-035 The first tick after reset release SHALL require an observed 0-to-1 transition of slow_clk.

Structure
REQ-036 Shared package irrigation_pkg SHALL hold the state enum, the mode encodings (MODE_OFF, MODE_SPRINKLER, MODE_DRIP) and the 6-bit tick-count width constant.
REQ-037 Sub-module tick_sync (synchronizer and rising-edge detector) SHALL produce tick; the FSM and counter SHALL reside in irrigation_sequencer.

Verification (SPRINKLER_TICKS=3, DRIP_TICKS=5)
REQ-038 start=1 with mode=01 and tank_low=0, then 3 slow_clk rises: valve_sprinkler=1 and busy=1, remaining steps 3->2->1->0, done pulses once, return to IDLE with outputs 0.
REQ-039 start with mode=10, then stop=1 after 2 ticks: remaining=3 before stop, then valves 0, remaining 0, no done, IDLE.
REQ-040 mode=01 during WATER, tank_low=1 at remaining=2: alarm=1 and valves 0; stop=1 with tank_low=1 keeps ALARM; stop=1 with tank_low=0 returns to IDLE.
REQ-041 start with mode=11, and start with mode=00: no state change and all outputs remain 0.
REQ-042 rst pulse mid-WATER, asynchronous to clk: outputs 0 immediately; slow_clk held high through reset release produces no tick.
REQ-043 stop and tank_low rise in the same cycle during WATER: IDLE is taken, alarm stays 0.
